// File: rtl/uart_pkg.sv
// uart_pkg: shared UART states, frame constants and baud divisor helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk down to the 16x oversample tick, held in phase by clear
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] pcnt_q, pcnt_d;
  // tick on the last count of each period; clear parks the counter at zero
  always_comb begin
    tick   = !clear && pcnt_q == W'(DIV - 1);
    pcnt_d = (clear || tick) ? '0 : pcnt_q + W'(1);
  end
  // period counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) pcnt_q <= '0;
    else pcnt_q <= pcnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 16x oversampling, 3-sample majority vote and framing-error report
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DIV       = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_dat,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);
  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic                 prev_q, prev_d;
  logic [3:0]           scnt_q, scnt_d, scnt_n;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, rx_dat_q, rx_dat_d;
  logic                 rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic                 rxs, tick, bit_v, decide;
  assign rxs = sync_q[1];
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == IDLE || state_q == WAIT_IDLE),
    .tick (tick)
  );
  // next state: edge detect, sample collection, majority decision at sample 9
  always_comb begin
    sync_d      = {sync_q[0], rx};
    prev_d      = rxs;
    state_d     = state_q;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    vote_d      = vote_q;
    shreg_d     = shreg_q;
    rx_dat_d    = rx_dat_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    scnt_n      = scnt_q + 4'd1;
    bit_v       = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);
    decide      = tick && scnt_n == 4'd9;
    if (state_q == IDLE) begin
      scnt_d  = '0;
      bcnt_d  = '0;
      state_d = (prev_q && !rxs) ? START : IDLE;
    end else if (state_q == WAIT_IDLE) begin
      state_d = rxs ? IDLE : WAIT_IDLE;
    end else if (tick) begin
      scnt_d    = scnt_n;
      vote_d[0] = scnt_n == 4'd7 ? rxs : vote_q[0];
      vote_d[1] = scnt_n == 4'd8 ? rxs : vote_q[1];
    end
    if (decide) begin
      unique case (state_q)
        START: state_d = bit_v ? IDLE : DATA;
        DATA: begin
          shreg_d = {bit_v, shreg_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + 3'd1;
          state_d = bcnt_q == 3'(DATA_BITS - 1) ? STOP : DATA;
        end
        STOP: begin
          rx_valid_d  = bit_v;
          frame_err_d = !bit_v;
          rx_dat_d    = bit_v ? shreg_q : rx_dat_q;
          state_d     = bit_v ? IDLE : WAIT_IDLE;
        end
        default: ;
      endcase
    end
  end
  // state and datapath registers; sync flops reset to the idle line level
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      vote_q      <= '0;
      shreg_q     <= '0;
      rx_dat_q    <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      vote_q      <= vote_d;
      shreg_q     <= shreg_d;
      rx_dat_q    <= rx_dat_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  assign rx_dat    = rx_dat_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx with a 4-clk sample tick (64 clk per bit)
module tb_uart_rx;
  localparam int DIV = 4;
  localparam int BT  = 16 * DIV;
  logic       clk = 1'b0, rst = 1'b0, rx = 1'b1;
  logic [7:0] rx_dat;
  logic       rx_valid, frame_err, busy;
  int         checks = 0, errors = 0;
  int         nvalid = 0, nferr = 0, nboth = 0, cyc = 0, valid_cyc = 0, c0, v0, f0;
  logic [7:0] dat_log [16];
  uart_rx #(.CLK_FREQ(640000), .BAUD_RATE(10000)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_dat   (rx_dat),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // count every cycle a strobe is high, so a stretched pulse shows up as an extra count
  always @(negedge clk) begin
    if (rx_valid) begin
      dat_log[nvalid[3:0]] = rx_dat;
      nvalid++;
      valid_cyc = cyc;
    end
    if (frame_err) nferr++;
    if (rx_valid && frame_err) nboth++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // drive one frame from a negedge; spike inverts the line for sample slot 8 of every bit
  task automatic send(input logic [7:0] b, input int bt, input logic stop, input bit spike, input int limit);
    logic [9:0] f;
    int n;
    f = {stop, b, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < bt; c++) begin
        if (n == limit) return;
        rx = (spike && c >= 8 * DIV && c < 9 * DIV) ? ~f[i] : f[i];
        @(negedge clk);
        n++;
      end
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_dat", rx_dat, 8'h00);
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_ferr", frame_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b1;
    idle(10);
    c0 = cyc;
    send(8'hA5, BT, 1'b1, 1'b0, 10000);
    idle(20);
    chk("single_count", nvalid, 1);
    chk("single_dat", rx_dat, 8'hA5);
    chk("single_log", dat_log[0], 8'hA5);
    chk("single_ferr", nferr, 0);
    chk("single_busy", busy, 1'b0);
    chk("single_latency_615pm1", (valid_cyc - c0 >= 614) && (valid_cyc - c0 <= 616), 1'b1);
    send(8'h00, BT + 1, 1'b1, 1'b0, 10000);
    send(8'hFF, BT + 1, 1'b1, 1'b0, 10000);
    send(8'h3C, BT + 1, 1'b1, 1'b0, 10000);
    idle(100);
    chk("b2b_count", nvalid, 4);
    chk("b2b_dat0", dat_log[1], 8'h00);
    chk("b2b_dat1", dat_log[2], 8'hFF);
    chk("b2b_dat2", dat_log[3], 8'h3C);
    chk("b2b_ferr", nferr, 0);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_high", busy, 1'b1);
    idle(100);
    chk("glitch_busy_low", busy, 1'b0);
    chk("glitch_no_valid", nvalid, 4);
    chk("glitch_no_ferr", nferr, 0);
    send(8'h55, BT, 1'b0, 1'b0, 10000);
    repeat (20 * BT) @(negedge clk);
    chk("badstop_ferr_once", nferr, 1);
    chk("badstop_no_valid", nvalid, 4);
    chk("badstop_dat_held", rx_dat, 8'h3C);
    chk("badstop_wait_busy", busy, 1'b1);
    idle(20);
    chk("badstop_busy_low", busy, 1'b0);
    send(8'h12, BT, 1'b1, 1'b0, 10000);
    idle(20);
    chk("after_bad_dat", rx_dat, 8'h12);
    chk("after_bad_count", nvalid, 5);
    send(8'hC3, BT, 1'b1, 1'b1, 10000);
    idle(20);
    chk("noise_dat", rx_dat, 8'hC3);
    chk("noise_count", nvalid, 6);
    chk("noise_ferr", nferr, 1);
    v0 = nvalid;
    f0 = nferr;
    send(8'h81, BT, 1'b1, 1'b0, 5 * BT + 20);
    chk("midreset_busy_before", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("midreset_dat", rx_dat, 8'h00);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_valid", rx_valid, 1'b0);
    chk("midreset_ferr", frame_err, 1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(10 * BT);
    chk("midreset_no_valid", nvalid, v0);
    chk("midreset_no_ferr", nferr, f0);
    send(8'h7E, BT, 1'b1, 1'b0, 10000);
    idle(20);
    chk("after_reset_dat", rx_dat, 8'h7E);
    chk("after_reset_count", nvalid, v0 + 1);
    chk("never_both", nboth, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
